mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle MIPS control unit: the next-generation controller for the MIPS core. It replaces the combinational single-cycle decoder with a state machine driving a shared-memory multicycle datapath. It stalls on a ready-handshaked memory port, so it works behind the AXI cache/FIFO path. It adds optional BNE, ANDI and ORI support and an illegal-opcode trap.

Parameters:
ENABLE_BNE, 1, 1 = decode BNE (op 000101); 0 = BNE is illegal
ENABLE_LOGIC_IMM, 1, 1 = decode ANDI (001100) and ORI (001101) with zero-extended immediate; 0 = illegal
TRAP_ON_ILLEGAL, 1, 1 = illegal op/funct enters TRAP until reset; 0 = treated as NOP, return to FETCH

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces state to FETCH
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes current access this cycle
memreq  out  1  memory access request; held until mem_ready
memwrite  out  1  access is a store (valid only with memreq)
iord  out  1  0 = address from PC, 1 = address from ALUOut
irwrite  out  1  load instruction register
pcen  out  1  PC write enable (includes branch condition)
pcsrc  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate<<2
zext  out  1  immediate is zero-extended (ANDI/ORI), else sign-extended
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = write-back from memory data register
regwrite  out  1  register file write enable
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  out  1  high while in TRAP
state  out  4  current state, debug only

Behaviour:
- State encoding (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BRANCHEX=8, IMMEX=9, IMMWB=10, JEX=11, TRAP=15.
- Reset: state=FETCH asynchronously. All outputs are decoded from state/inputs. The reset values are therefore the FETCH values: memreq=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010; all other outputs 0.
- Every output not listed for a state is 0. alusrcb and pcsrc default to 00. alucontrol defaults to 010.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, add.
  - mem_ready=0: stay in FETCH; irwrite=0, pcen=0.
  - mem_ready=1: irwrite=1, pcen=1 (PC<=PC+4), go to DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - LW/SW -> MEMADR; R-type -> RTYPEEX; BEQ/BNE -> BRANCHEX; ADDI/ANDI/ORI -> IMMEX; J -> JEX.
  - Disabled or unknown op -> TRAP if TRAP_ON_ILLEGAL, else FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. LW -> MEMRD; SW -> MEMWR.
- MEMRD: memreq=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Wait for mem_ready, then go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Go to RTYPEWB.
  - Unknown funct -> TRAP or FETCH per TRAP_ON_ILLEGAL; no write-back occurs.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for BEQ; pcen = ~zero for BNE.
  - Go to FETCH.
- IMMEX: alusrca=1, alusrcb=10. ADDI: add, zext=0. ANDI: and, zext=1. ORI: or, zext=1. Go to IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- JEX: pcsrc=10, pcen=1. Go to FETCH.
- TRAP: illegal=1, all enables 0, memreq=0. Only reset exits.
- Memory handshake:
  - memreq, iord and memwrite are held stable from the first request cycle until and including the mem_ready cycle.
  - mem_ready is ignored in states with memreq=0.
  - A mem_ready already high on the first request cycle completes the access in that cycle (zero wait states).
- Reset mid-access (MEMRD, MEMWR, FETCH wait): the request is abandoned, with no irwrite, pcen or regwrite pulse. Restart in FETCH.
- CPI with zero wait states: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3. Each wait cycle on a memory access adds 1.

Test Plan:
- LW, mem_ready low 2 cycles in FETCH and 1 in MEMRD -> states 0,0,0,1,2,3,3,4,0; irwrite and pcen pulse once, regwrite pulses once in MEMWB; 8 cycles total.
- BEQ with zero=1, then BNE with zero=1 -> pcen=1 in BRANCHEX for BEQ, pcen=0 for BNE; both pcsrc=01, alucontrol=110.
- ORI (op 001101) -> IMMEX has zext=1, alucontrol=001, alusrcb=10; IMMWB has regwrite=1, regdst=0.
- ENABLE_BNE=0, op 000101 -> DECODE goes to TRAP (state=15); illegal stays 1 and memreq 0 for 20 cycles until reset, then state=0.
- TRAP_ON_ILLEGAL=0, R-type funct 000000 -> RTYPEEX then FETCH; regwrite never asserted.
- Reset asserted mid-MEMWR while mem_ready=0 -> state=0 asynchronously; memwrite drops immediately; no regwrite or pcen pulse; next fetch completes normally.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - control/status bundle between the multicycle MIPS controller and its datapath
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memreq;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zext;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           zext, regdst, memtoreg, regwrite, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           zext, regdst, memtoreg, regwrite, alucontrol, illegal, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with ready-handshaked shared memory port
module mips_mc_controller #(
  parameter bit ENABLE_BNE       = 1'b1,
  parameter bit ENABLE_LOGIC_IMM = 1'b1,
  parameter bit TRAP_ON_ILLEGAL  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_mc_controller_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCHEX = 4'd8,
    S_IMMEX    = 4'd9,
    S_IMMWB    = 4'd10,
    S_JEX      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Where an unsupported op/funct lands: a sticky trap, or silently skip it as a NOP.
  localparam state_t ILL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.state = state_q;

  always_comb begin
    state_d        = state_q;
    bus.memreq     = 1'b0;
    bus.memwrite   = 1'b0;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.pcen       = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.zext       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alucontrol = ALU_ADD;
    bus.illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.memreq  = 1'b1;
        bus.alusrcb = 2'b01;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcen    = 1'b1;
          state_d     = S_DECODE;
        end
      end

      // ALU precomputes the branch target into ALUOut while the op is decoded.
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BRANCHEX;
          OP_BNE:       state_d = ENABLE_BNE ? S_BRANCHEX : ILL_NEXT;
          OP_ADDI:      state_d = S_IMMEX;
          OP_ANDI,
          OP_ORI:       state_d = ENABLE_LOGIC_IMM ? S_IMMEX : ILL_NEXT;
          OP_J:         state_d = S_JEX;
          default:      state_d = ILL_NEXT;
        endcase
      end

      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        bus.memreq = 1'b1;
        bus.iord   = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        bus.memreq   = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        state_d     = S_RTYPEWB;
        case (bus.funct)
          FN_ADD:  bus.alucontrol = ALU_ADD;
          FN_SUB:  bus.alucontrol = ALU_SUB;
          FN_AND:  bus.alucontrol = ALU_AND;
          FN_OR:   bus.alucontrol = ALU_OR;
          FN_SLT:  bus.alucontrol = ALU_SLT;
          default: state_d        = ILL_NEXT;
        endcase
      end

      S_RTYPEWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = S_FETCH;
      end

      // Only BNE can reach here with op 000101, so no need to re-check ENABLE_BNE.
      S_BRANCHEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        bus.pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        state_d        = S_FETCH;
      end

      S_IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = S_IMMWB;
        case (bus.op)
          OP_ANDI: begin
            bus.alucontrol = ALU_AND;
            bus.zext       = 1'b1;
          end
          OP_ORI: begin
            bus.alucontrol = ALU_OR;
            bus.zext       = 1'b1;
          end
          default: bus.alucontrol = ALU_ADD;
        endcase
      end

      S_IMMWB: begin
        bus.regwrite = 1'b1;
        state_d      = S_FETCH;
      end

      S_JEX: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        bus.illegal = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed-vector bench for the multicycle MIPS controller
module tb_mips_mc_controller;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  mips_mc_controller_if bus0 ();
  mips_mc_controller_if bus1 ();
  mips_mc_controller_if bus2 ();

  mips_mc_controller dut0 (.clk(clk), .reset(rst0), .bus(bus0));
  mips_mc_controller #(.ENABLE_BNE(1'b0)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  mips_mc_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned lw_state [8] = '{0, 0, 0, 1, 2, 3, 3, 4};
  logic        lw_ready [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned rt_state [4] = '{0, 1, 6, 0};

  initial begin
    int ir_cnt, pc_cnt, rw_cnt;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.op = 6'd0; bus0.funct = 6'd0; bus0.zero = 1'b0; bus0.mem_ready = 1'b0;
    bus1.op = 6'd0; bus1.funct = 6'd0; bus1.zero = 1'b0; bus1.mem_ready = 1'b0;
    bus2.op = 6'd0; bus2.funct = 6'd0; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;
    tick();
    tick();

    check("rst_state",   bus0.state, 0);
    check("rst_memreq",  bus0.memreq, 1);
    check("rst_iord",    bus0.iord, 0);
    check("rst_alusrcb", bus0.alusrcb, 1);
    check("rst_aluctl",  bus0.alucontrol, 3'b010);
    check("rst_irwrite", bus0.irwrite, 0);
    check("rst_pcen",    bus0.pcen, 0);
    check("rst_illegal", bus0.illegal, 0);

    // LW with two fetch wait states and one read wait state
    rst0 = 1'b0;
    bus0.op = 6'b100011;
    ir_cnt = 0; pc_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus0.mem_ready = lw_ready[i];
      #1;
      check($sformatf("lw_state%0d", i), bus0.state, lw_state[i]);
      ir_cnt += int'(bus0.irwrite);
      pc_cnt += int'(bus0.pcen);
      rw_cnt += int'(bus0.regwrite);
      if (i == 5) begin
        check("lw_memrd_memreq", bus0.memreq, 1);
        check("lw_memrd_iord", bus0.iord, 1);
      end
      if (i == 7) check("lw_memwb_memtoreg", bus0.memtoreg, 1);
      tick();
    end
    check("lw_end_state", bus0.state, 0);
    check("lw_irwrite_pulses", ir_cnt, 1);
    check("lw_pcen_pulses", pc_cnt, 1);
    check("lw_regwrite_pulses", rw_cnt, 1);

    // BEQ taken, BNE not taken, BNE taken
    bus0.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus0.op   = (k == 0) ? 6'b000100 : 6'b000101;
      bus0.zero = (k == 2) ? 1'b0 : 1'b1;
      tick();
      tick();
      check($sformatf("br%0d_state", k), bus0.state, 8);
      check($sformatf("br%0d_pcen", k), bus0.pcen, (k == 1) ? 0 : 1);
      check($sformatf("br%0d_pcsrc", k), bus0.pcsrc, 1);
      check($sformatf("br%0d_aluctl", k), bus0.alucontrol, 3'b110);
      tick();
      check($sformatf("br%0d_next", k), bus0.state, 0);
    end

    // ORI
    bus0.op = 6'b001101;
    bus0.zero = 1'b0;
    tick();
    tick();
    check("ori_state", bus0.state, 9);
    check("ori_zext", bus0.zext, 1);
    check("ori_aluctl", bus0.alucontrol, 3'b001);
    check("ori_alusrcb", bus0.alusrcb, 2);
    tick();
    check("oriwb_state", bus0.state, 10);
    check("oriwb_regwrite", bus0.regwrite, 1);
    check("oriwb_regdst", bus0.regdst, 0);
    tick();
    check("ori_next", bus0.state, 0);

    // J
    bus0.op = 6'b000010;
    tick();
    tick();
    check("j_state", bus0.state, 11);
    check("j_pcsrc", bus0.pcsrc, 2);
    check("j_pcen", bus0.pcen, 1);
    tick();

    // SW, reset asserted while the write is stalled
    bus0.op = 6'b101011;
    tick();
    tick();
    tick();
    bus0.mem_ready = 1'b0;
    #1;
    check("sw_state", bus0.state, 5);
    check("sw_memwrite", bus0.memwrite, 1);
    tick();
    check("sw_hold_memwrite", bus0.memwrite, 1);
    #2;
    rst0 = 1'b1;
    #1;
    check("swrst_state", bus0.state, 0);
    check("swrst_memwrite", bus0.memwrite, 0);
    check("swrst_regwrite", bus0.regwrite, 0);
    check("swrst_pcen", bus0.pcen, 0);
    check("swrst_irwrite", bus0.irwrite, 0);
    rst0 = 1'b0;
    bus0.mem_ready = 1'b1;
    #1;
    check("refetch_irwrite", bus0.irwrite, 1);
    check("refetch_pcen", bus0.pcen, 1);
    tick();
    check("refetch_next", bus0.state, 1);

    // BNE disabled -> sticky trap
    rst1 = 1'b0;
    bus1.op = 6'b000101;
    bus1.mem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("trap_state%0d", i), bus1.state, 15);
      check($sformatf("trap_illegal%0d", i), bus1.illegal, 1);
      check($sformatf("trap_memreq%0d", i), bus1.memreq, 0);
      tick();
    end
    rst1 = 1'b1;
    #1;
    check("trap_rst_state", bus1.state, 0);
    check("trap_rst_illegal", bus1.illegal, 0);

    // Unknown funct treated as NOP
    rst2 = 1'b0;
    bus2.op = 6'b000000;
    bus2.funct = 6'b000000;
    bus2.mem_ready = 1'b1;
    rw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("nop_state%0d", i), bus2.state, rt_state[i]);
      rw_cnt += int'(bus2.regwrite);
      tick();
    end
    check("nop_regwrite", rw_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
